nrisc_ula_pipe: RTL and testbench

- Parametrised, handshaked successor of the NRISC ULA: TAM-bit datapath with registered result and flags.
- Adds multi-bit barrel shifts/rotates, arithmetic shift right, compare and an iterative unsigned multiply (low half).
- Sits between the register-file read stage and writeback.
- valid/ready on both sides lets the multi-cycle multiply stall the upstream pipeline.

---
 rtl/nrisc_ula_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_nrisc_ula_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nrisc_ula_pipe.sv
// Pipelined NRISC ULA: single-cycle ALU ops and an iterative shift-add multiply,
// with valid/ready handshakes on both sides and a registered result/flags stage.
module nrisc_ula_pipe #(
  parameter int TAM = 16,
  parameter int SHW = $clog2(TAM)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [TAM-1:0] ULA_A,
  input  logic [TAM-1:0] ULA_B,
  input  logic [3:0]     ULA_ctrl,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [TAM-1:0] ULA_OUT,
  output logic [3:0]     ULA_flags,
  output logic           ULA_err
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_ASR  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_CMP  = 4'b1010;
  localparam logic [3:0] OP_ROTR = 4'b1101;
  localparam logic [3:0] OP_ROTL = 4'b1110;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(TAM - 1);
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [TAM-1:0]   out_q, out_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic [2*TAM-1:0] mcand_q, mcand_d;
  logic [TAM-1:0]   mplier_q, mplier_d;
  logic [2*TAM-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [SHW-1:0]   shamt_s;
  logic [SHW-1:0]   shamt_neg_s;
  logic [TAM:0]     sum_s;
  logic [TAM:0]     diff_s;
  logic [TAM:0]     shl_w_s;
  logic [TAM:0]     shr_w_s;
  logic [TAM:0]     asr_w_s;
  logic [2*TAM-1:0] rot_w_s;
  logic [TAM-1:0]   alu_res_s;
  logic [3:0]       alu_flags_s;
  logic             alu_err_s;
  logic [2*TAM-1:0] acc_step_s;
  logic             accept_s;
  logic             out_free_s;

  // Packs {V,C,N,Z}; N and Z always come from the value the flags describe.
  function automatic logic [3:0] mk_flags(input logic v, input logic c, input logic [TAM-1:0] val);
    mk_flags = {v, c, val[TAM-1], ~|val};
  endfunction

  // Single-cycle ALU; the extra bit on each shift vector captures the last bit shifted out.
  always_comb begin
    shamt_s     = ULA_B[SHW-1:0];
    shamt_neg_s = {SHW{1'b0}} - shamt_s;
    sum_s       = {1'b0, ULA_A} + {1'b0, ULA_B};
    diff_s      = {1'b0, ULA_A} - {1'b0, ULA_B};
    shl_w_s     = {1'b0, ULA_A} << shamt_s;
    shr_w_s     = {ULA_A, 1'b0} >> shamt_s;
    asr_w_s     = $signed({ULA_A, 1'b0}) >>> shamt_s;
    rot_w_s     = {ULA_A, ULA_A};
    alu_res_s   = {TAM{1'b0}};
    alu_flags_s = 4'b0000;
    alu_err_s   = 1'b0;
    case (ULA_ctrl)
      OP_ADD: begin
        alu_res_s   = sum_s[TAM-1:0];
        alu_flags_s = mk_flags((ULA_A[TAM-1] == ULA_B[TAM-1]) && (sum_s[TAM-1] != ULA_A[TAM-1]),
                               sum_s[TAM], sum_s[TAM-1:0]);
      end
      OP_SUB, OP_CMP: begin
        alu_res_s   = (ULA_ctrl == OP_CMP) ? ULA_A : diff_s[TAM-1:0];
        alu_flags_s = mk_flags((ULA_A[TAM-1] != ULA_B[TAM-1]) && (diff_s[TAM-1] != ULA_A[TAM-1]),
                               diff_s[TAM], diff_s[TAM-1:0]);
      end
      OP_AND: begin
        alu_res_s   = ULA_A & ULA_B;
        alu_flags_s = mk_flags(1'b0, 1'b0, ULA_A & ULA_B);
      end
      OP_OR: begin
        alu_res_s   = ULA_A | ULA_B;
        alu_flags_s = mk_flags(1'b0, 1'b0, ULA_A | ULA_B);
      end
      OP_XOR: begin
        alu_res_s   = ULA_A ^ ULA_B;
        alu_flags_s = mk_flags(1'b0, 1'b0, ULA_A ^ ULA_B);
      end
      OP_NOT: begin
        alu_res_s   = ~ULA_A;
        alu_flags_s = mk_flags(1'b0, 1'b0, ~ULA_A);
      end
      OP_SHR: begin
        alu_res_s   = shr_w_s[TAM:1];
        alu_flags_s = mk_flags(1'b0, shr_w_s[0], shr_w_s[TAM:1]);
      end
      OP_ASR: begin
        alu_res_s   = asr_w_s[TAM:1];
        alu_flags_s = mk_flags(1'b0, asr_w_s[0], asr_w_s[TAM:1]);
      end
      OP_SHL: begin
        alu_res_s   = shl_w_s[TAM-1:0];
        alu_flags_s = mk_flags(1'b0, shl_w_s[TAM], shl_w_s[TAM-1:0]);
      end
      OP_ROTR: begin
        alu_res_s   = TAM'(rot_w_s >> shamt_s);
        alu_flags_s = mk_flags(1'b0, 1'b0, TAM'(rot_w_s >> shamt_s));
      end
      OP_ROTL: begin
        alu_res_s   = TAM'(rot_w_s >> shamt_neg_s);
        alu_flags_s = mk_flags(1'b0, 1'b0, TAM'(rot_w_s >> shamt_neg_s));
      end
      OP_MUL: begin
        alu_res_s   = {TAM{1'b0}};
        alu_flags_s = 4'b0000;
      end
      default: begin
        alu_res_s   = {TAM{1'b0}};
        alu_flags_s = 4'b0000;
        alu_err_s   = 1'b1;
      end
    endcase
  end

  // Handshake, output-register and multiply sequencing.
  always_comb begin
    out_free_s  = !out_valid_q || out_ready;
    in_ready    = (state_q == ST_IDLE) && out_free_s;
    accept_s    = in_valid && in_ready;
    acc_step_s  = acc_q + (mplier_q[0] ? mcand_q : {(2*TAM){1'b0}});
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    out_d       = out_q;
    flags_d     = flags_q;
    err_d       = err_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (state_q == ST_IDLE) begin
      if (accept_s && (ULA_ctrl == OP_MUL)) begin
        state_d  = ST_MUL;
        mcand_d  = {{TAM{1'b0}}, ULA_A};
        mplier_d = ULA_B;
        acc_d    = {(2*TAM){1'b0}};
        cnt_d    = {SHW{1'b0}};
      end else if (accept_s) begin
        out_valid_d = 1'b1;
        out_d       = alu_res_s;
        flags_d     = alu_flags_s;
        err_d       = alu_err_s;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      // Final step only retires once the output register is free; otherwise everything holds.
      if ((cnt_q == CNT_LAST) && out_free_s) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b1;
        out_d       = acc_step_s[TAM-1:0];
        flags_d     = mk_flags(1'b0, |acc_step_s[2*TAM-1:TAM], acc_step_s[TAM-1:0]);
        err_d       = 1'b0;
        acc_d       = acc_step_s;
        cnt_d       = {SHW{1'b0}};
      end else if (cnt_q != CNT_LAST) begin
        acc_d    = acc_step_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
      end else begin
        state_d = ST_MUL;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_q       <= {TAM{1'b0}};
      flags_q     <= 4'b0000;
      err_q       <= 1'b0;
      mcand_q     <= {(2*TAM){1'b0}};
      mplier_q    <= {TAM{1'b0}};
      acc_q       <= {(2*TAM){1'b0}};
      cnt_q       <= {SHW{1'b0}};
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ULA_OUT   = out_q;
  assign ULA_flags = flags_q;
  assign ULA_err   = err_q;

endmodule

// File: tb/tb_nrisc_ula_pipe.sv
// Randomised bench for nrisc_ula_pipe: a cycle-level behavioural model with
// arithmetic reference results is compared against the DUT on every negedge.
module tb_nrisc_ula_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] ULA_A = 16'h0000;
  logic [15:0] ULA_B = 16'h0000;
  logic [3:0]  ULA_ctrl = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] ULA_OUT;
  logic [3:0]  ULA_flags;
  logic        ULA_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  nrisc_ula_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ULA_A(ULA_A), .ULA_B(ULA_B), .ULA_ctrl(ULA_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .ULA_OUT(ULA_OUT), .ULA_flags(ULA_flags), .ULA_err(ULA_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference result {out[15:0], flags{V,C,N,Z}, err} from plain arithmetic.
  function automatic logic [20:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned s;
    logic [31:0] w;
    logic [15:0] r;
    logic [15:0] fv;
    logic v;
    logic c;
    s = int'(b[3:0]);
    v = 1'b0;
    c = 1'b0;
    r = 16'h0000;
    case (op)
      4'b0000: begin
        w = 32'(a) + 32'(b); r = w[15:0]; c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'b0001, 4'b1010: begin
        r = a - b; c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: begin r = a >> s; c = (s != 0) ? a[s-1] : 1'b0; end
      4'b0110: begin r = a << s; c = (s != 0) ? a[16-s] : 1'b0; end
      4'b0111: r = ~a;
      4'b1000: begin r = 16'($signed(a) >>> s); c = (s != 0) ? a[s-1] : 1'b0; end
      4'b1001: begin w = 32'(a) * 32'(b); r = w[15:0]; c = (w[31:16] != 16'h0000); end
      4'b1101: begin w = (32'(a) >> s) | (32'(a) << (16 - s)); r = w[15:0]; end
      4'b1110: begin w = (32'(a) << s) | (32'(a) >> (16 - s)); r = w[15:0]; end
      default: return {16'h0000, 4'b0000, 1'b1};
    endcase
    fv = r;
    if (op == 4'b1010) r = a;
    return {r, v, c, fv[15], (fv == 16'h0000), 1'b0};
  endfunction

  // Cycle-level model: output register, consume, and a multiply that retires 16 edges after accept.
  logic        m_valid = 1'b0, m_err = 1'b0, m_loaded = 1'b0, m_rdy;
  logic [15:0] m_out = 16'h0000;
  logic [3:0]  m_flags = 4'b0000;
  logic [20:0] m_r, m_pend;
  int          m_left = 0;

  always @(posedge clk) begin
    m_rdy = (m_left == 0) && (!m_valid || out_ready);
    if (rst) begin
      m_valid = 1'b0; m_out = 16'h0000; m_flags = 4'b0000; m_err = 1'b0;
      m_left = 0; m_loaded = 1'b0;
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_left > 1) m_left = m_left - 1;
      else if (m_left == 1) begin
        if (!m_valid) begin
          {m_out, m_flags, m_err} = m_pend;
          m_valid = 1'b1; m_loaded = 1'b1; m_left = 0;
        end
      end else if (in_valid && m_rdy) begin
        m_r = ref_alu(ULA_ctrl, ULA_A, ULA_B);
        if (ULA_ctrl == 4'b1001) begin
          m_pend = m_r; m_left = 16;
        end else begin
          {m_out, m_flags, m_err} = m_r;
          m_valid = 1'b1; m_loaded = 1'b1;
        end
      end
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready", 32'(in_ready), 32'((m_left == 0) && (!m_valid || out_ready)));
      if (m_valid || !m_loaded) begin
        chk("ULA_OUT", 32'(ULA_OUT), 32'(m_out));
        chk("ULA_flags", 32'(ULA_flags), 32'(m_flags));
        chk("ULA_err", 32'(ULA_err), 32'(m_err));
      end
    end
  end

  // Called at negedge+1; returns at negedge+1 of the cycle after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    int k;
    ULA_A = a; ULA_B = b; ULA_ctrl = op; in_valid = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk); #2; k++;
    end
    if (k >= 200) chk("send_timeout", 32'(k), 32'(0));
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
  endtask

  initial begin
    int lat;
    // Pin the reference function to hand-computed values.
    chk("ref_add_ovf", 32'(ref_alu(4'b0000, 16'h7FFF, 16'h0001)), 32'({16'h8000, 4'b1010, 1'b0}));
    chk("ref_sub",     32'(ref_alu(4'b0001, 16'h0003, 16'h0005)), 32'({16'hFFFE, 4'b0110, 1'b0}));
    chk("ref_rotr",    32'(ref_alu(4'b1101, 16'h8001, 16'h0004)), 32'({16'h1800, 4'b0000, 1'b0}));
    chk("ref_asr",     32'(ref_alu(4'b1000, 16'h8001, 16'h0004)), 32'({16'hF800, 4'b0010, 1'b0}));
    chk("ref_shl",     32'(ref_alu(4'b0110, 16'h8001, 16'h0004)), 32'({16'h0010, 4'b0000, 1'b0}));
    chk("ref_shr",     32'(ref_alu(4'b0101, 16'h8001, 16'h0011)), 32'({16'h4000, 4'b0100, 1'b0}));
    chk("ref_mul",     32'(ref_alu(4'b1001, 16'h0123, 16'h0010)), 32'({16'h1230, 4'b0000, 1'b0}));
    chk("ref_mul_hi",  32'(ref_alu(4'b1001, 16'hFFFF, 16'h0002)), 32'({16'hFFFE, 4'b0110, 1'b0}));
    chk("ref_rsvd",    32'(ref_alu(4'b1011, 16'h1234, 16'h5678)), 32'({16'h0000, 4'b0000, 1'b1}));
    chk("ref_cmp",     32'(ref_alu(4'b1010, 16'h0005, 16'h0005)), 32'({16'h0005, 4'b0001, 1'b0}));

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk); #1 rst = 1'b0;

    send(16'h7FFF, 16'h0001, 4'b0000);
    chk("add_ovf_out", 32'(ULA_OUT), 32'h8000);
    send(16'h0003, 16'h0005, 4'b0001);
    send(16'h8001, 16'h0004, 4'b1101);
    send(16'h8001, 16'h0004, 4'b1000);
    send(16'h8001, 16'h0004, 4'b0110);
    send(16'h8001, 16'h0011, 4'b0101);
    send(16'h8001, 16'h0000, 4'b0110);
    send(16'h1234, 16'h5678, 4'b1011);
    send(16'h0005, 16'h0005, 4'b1010);
    idle(2);

    // Multiply latency, measured in cycles from the accept cycle.
    send(16'h0123, 16'h0010, 4'b1001);
    lat = 1;
    while (!out_valid && lat < 40) begin @(negedge clk); #1; lat++; end
    chk("mul_latency", 32'(lat), 32'd17);
    chk("mul_out", 32'(ULA_OUT), 32'h1230);
    send(16'hFFFF, 16'h0002, 4'b1001);
    idle(20);

    // Reset during the 5th multiply cycle aborts it.
    send(16'h00FF, 16'h00FF, 4'b1001);
    idle(4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_out", 32'(ULA_OUT), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    idle(25);

    // Backpressure: first result held while downstream stalls, then drain.
    out_ready = 1'b0;
    send(16'h0001, 16'h0001, 4'b0000);
    ULA_A = 16'h0002; ULA_B = 16'h0002; ULA_ctrl = 4'b0000; in_valid = 1'b1;
    idle(3);
    out_ready = 1'b1;
    send(16'h0002, 16'h0002, 4'b0000);
    send(16'h0003, 16'h0003, 4'b0000);
    idle(3);

    // Randomised traffic, including resets and shift-amount edge values.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      ULA_A     = 16'($urandom);
      ULA_B     = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
      if ($urandom_range(0, 7) == 0) ULA_A = 16'h8000;
      if ($urandom_range(0, 7) == 0) ULA_B = 16'h7FFF;
      ULA_ctrl  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 399) == 0);
      @(negedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
